// File: rtl/ram_sp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : ram_sp_arbiter_if
// Brief  : Client-side bundle for the two-requester single-port RAM arbiter.
//          Two req/gnt command channels plus the shared read-return bus.
//   master : client engines (drive req/we/addr/wdata, see gnt/rvalid/rdata)
//   slave  : arbiter        (sees commands, drives gnt/rvalid/rdata)
// Rev    : 1.0  initial release
// ============================================================================
interface ram_sp_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );
endinterface
`default_nettype wire

// File: rtl/ram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_sp_arbiter
// Brief  : Round-robin arbiter with bounded bursts sharing one single-port
//          write-first RAM between two requesters.
// Ports  : clk      rising-edge clock
//          rst      asynchronous active-high reset
//          bus      client bundle (req/we/addr/wdata/gnt/rvalid x2, rdata)
//          ram_en   RAM enable          ram_we   RAM write enable
//          ram_addr RAM address         ram_di   RAM write data
//          ram_do   RAM read data       busy     a burst owner is held
// Rev    : 1.0  initial release
// ============================================================================
module ram_sp_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ram_sp_arbiter_if.slave    bus,
  output logic               ram_en,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_di,
  input  wire logic [DW-1:0] ram_do,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
  localparam logic [3:0] c_cnt_sat   = 4'hF;

  own_t       r_own;
  logic [3:0] r_cnt;
  logic       r_last;     // 1: requester 1 was granted most recently
  logic       r_rvalid0;
  logic       r_rvalid1;

  // Raw grant decision from the registered state only; it feeds the state
  // flops. The port-visible grant is additionally masked by rst so that the
  // outputs follow the reset state while rst is held, without routing the
  // asynchronous reset into any flop's data path.
  logic w_raw0;
  logic w_raw1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any;
  logic w_same;

  always_comb begin
    w_raw0 = 1'b0;
    w_raw1 = 1'b0;
    case (r_own)
      IDLE: begin
        w_raw0 = bus.req0 & (~bus.req1 | r_last);
        w_raw1 = bus.req1 & ~w_raw0;
      end
      OWN0: begin
        if (bus.req0) begin
          if ((r_cnt < c_max_burst) || !bus.req1) w_raw0 = 1'b1;
          else                                    w_raw1 = 1'b1;
        end else begin
          w_raw1 = bus.req1;
        end
      end
      OWN1: begin
        if (bus.req1) begin
          if ((r_cnt < c_max_burst) || !bus.req0) w_raw1 = 1'b1;
          else                                    w_raw0 = 1'b1;
        end else begin
          w_raw0 = bus.req0;
        end
      end
      default: begin
        w_raw0 = 1'b0;
        w_raw1 = 1'b0;
      end
    endcase
  end

  assign w_gnt0 = w_raw0 & ~rst;
  assign w_gnt1 = w_raw1 & ~rst;
  assign w_any  = w_raw0 | w_raw1;
  assign w_same = (w_raw0 && (r_own == OWN0)) || (w_raw1 && (r_own == OWN1));

  // RAM command mux; with no grant the address/data rest on requester 0.
  assign ram_en   = w_gnt0 | w_gnt1;
  assign ram_we   = w_gnt1 ? bus.we1    : (w_gnt0 & bus.we0);
  assign ram_addr = w_gnt1 ? bus.addr1  : bus.addr0;
  assign ram_di   = w_gnt1 ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0    = w_gnt0;
  assign bus.gnt1    = w_gnt1;
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata   = ram_do;
  assign busy        = (r_own != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own     <= IDLE;
      r_cnt     <= 4'd0;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_raw0 & ~bus.we0;
      r_rvalid1 <= w_raw1 & ~bus.we1;
      if (w_any) begin
        r_own  <= w_raw1 ? OWN1 : OWN0;
        r_last <= w_raw1;
        if (w_same) r_cnt <= (r_cnt == c_cnt_sat) ? r_cnt : r_cnt + 4'd1;
        else        r_cnt <= 4'd1;
      end else begin
        r_own <= IDLE;
        r_cnt <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_sp_arbiter
// Brief  : Directed self-checking bench for ram_sp_arbiter with a behavioural
//          64x16 write-first RAM and a read-return scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_sp_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;
  logic          busy;
  logic          load;

  ram_sp_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_sp_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 16'hA5A5 : 16'(16'h1000 + i * 3);
  endfunction

  // Behavioural RAM: registered read address, enable-gated, write-first.
  logic [DW-1:0] mem [0:63];
  logic [AW-1:0] rd_addr;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      rd_addr <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      rd_addr <= ram_addr;
    end
  end
  assign ram_do = mem[rd_addr];

  typedef struct {
    logic [DW-1:0] data;
    logic          id;
  } exp_t;

  exp_t          sbq [$];
  logic [DW-1:0] shadow [0:63];
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check the combinational grant at the falling edge,
  // record expected read returns, then check rvalid/rdata after the edge.
  task automatic cyc(input logic g0, input logic g1);
    logic e0, e1;
    exp_t e;
    @(negedge clk);
    chk("gnt0", bus.gnt0, g0);
    chk("gnt1", bus.gnt1, g1);
    chk("gnt_excl", bus.gnt0 & bus.gnt1, 1'b0);
    chk("ram_en", ram_en, g0 | g1);
    chk("ram_we", ram_we, g0 ? bus.we0 : (g1 ? bus.we1 : 1'b0));
    if (g0 | g1) chk("ram_addr", ram_addr, g1 ? bus.addr1 : bus.addr0);
    if (g0 && bus.we0) shadow[bus.addr0] = bus.wdata0;
    if (g1 && bus.we1) shadow[bus.addr1] = bus.wdata1;
    e0 = g0 & ~bus.we0;
    e1 = g1 & ~bus.we1;
    if (e0 | e1) begin
      e.data = shadow[g1 ? bus.addr1 : bus.addr0];
      e.id   = e1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("rvalid0", bus.rvalid0, e0);
    chk("rvalid1", bus.rvalid1, e1);
    if (bus.rvalid0 | bus.rvalid1) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("rdata", bus.rdata, e.data);
        chk("rid", bus.rvalid1, e.id);
      end
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
    load = 1'b1;
    rst  = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    @(posedge clk);
    #1;
    load = 1'b0;

    // Reset state, with a request already pending.
    bus.req0 = 1'b1; bus.addr0 = 6'd5;
    @(negedge clk);
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_gnt1", bus.gnt1, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First read of RAM[5].
    cyc(1'b1, 1'b0);
    chk("busy_own0", busy, 1'b1);
    bus.req0 = 1'b0;
    cyc(1'b0, 1'b0);
    chk("busy_idle", busy, 1'b0);

    // Contention, MAX_BURST=4: 0,0,0,0,1,1,1,1,...
    rst_pulse();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd3;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd40;
    for (int i = 0; i < 16; i++) begin
      cyc((i % 8) < 4, (i % 8) >= 4);
      if ((i % 8) < 4) bus.addr0 = bus.addr0 + 6'd1;
      else             bus.addr1 = bus.addr1 + 6'd1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc(1'b0, 1'b0);

    // Requester 1 writes, requester 0 reads it back the next cycle.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd10; bus.wdata1 = 16'h1234;
    cyc(1'b0, 1'b1);
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd10;
    cyc(1'b1, 1'b0);
    bus.req0 = 1'b0;

    // Requester 1 alone: no burst limit, counter saturates.
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd7;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
    chk("cnt_sat", dut.r_cnt, 4'd15);
    bus.req1 = 1'b0;
    cyc(1'b0, 1'b0);
    chk("cnt_idle", dut.r_cnt, 4'd0);

    // Reset in the middle of an OWN0 burst while a read is being granted.
    rst_pulse();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("cnt_two", dut.r_cnt, 4'd2);
    @(negedge clk);
    chk("pre_rst_gnt0", bus.gnt0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt0", bus.gnt0, 1'b0);
    chk("mid_rst_ram_en", ram_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rvalid0", bus.rvalid0, 1'b0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd20;
    @(posedge clk);
    #1;
    chk("post_rst_rvalid0", bus.rvalid0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);

    // Requester 0 drops mid-burst while requester 1 waits.
    cyc(1'b1, 1'b0);
    bus.req0 = 1'b0;
    cyc(1'b0, 1'b1);
    chk("drop_cnt", dut.r_cnt, 4'd1);
    chk("drop_last", dut.r_last, 1'b1);
    bus.req1 = 1'b0;
    cyc(1'b0, 1'b0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
